// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp decode for the intersection controller.
package traffic_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        WALK_A = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        WALK_B = 3'd5
    } phase_t;

    typedef struct packed {
        logic main_g;
        logic main_y;
        logic main_r;
        logic side_g;
        logic side_y;
        logic side_r;
        logic walk;
    } lamps_t;

    function automatic lamps_t lamp_decode(input phase_t p);
        lamps_t l;
        l = '0;
        case (p)
            MAIN_G: begin l.main_g = 1'b1; l.side_r = 1'b1; end
            MAIN_Y: begin l.main_y = 1'b1; l.side_r = 1'b1; end
            SIDE_G: begin l.main_r = 1'b1; l.side_g = 1'b1; end
            SIDE_Y: begin l.main_r = 1'b1; l.side_y = 1'b1; end
            WALK_A, WALK_B: begin l.main_r = 1'b1; l.side_r = 1'b1; l.walk = 1'b1; end
            // Unused codes show all-red for the single clk before recovery.
            default: begin l.main_r = 1'b1; l.side_r = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_walk_debounce.sv
// One pedestrian button debouncer: output high after DEB_LEN consecutive high samples.
module walk_debounce #(
    parameter int DEB_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    logic [DEB_LEN-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEB_LEN-2:0], raw};
        end
    end

    assign deb = &sr;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection sequencer with on-demand all-red walk phases and jam-extended greens.
// Lamps change 1 clk after the tick that ends a phase; no backpressure, outputs are plain levels.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int NUM_WALK   = 4,
    parameter int DEB_LEN    = 3,
    parameter int CNT_W      = 8,
    parameter int T_MAIN_G   = 12,
    parameter int T_SIDE_G   = 6,
    parameter int T_YEL      = 2,
    parameter int T_WALK     = 3,
    parameter int T_JAM_G    = 9,
    parameter int JAM_SAMPLE = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sensor,
    input  logic [NUM_WALK-1:0] walk_req,
    output logic                main_g,
    output logic                main_y,
    output logic                main_r,
    output logic                side_g,
    output logic                side_y,
    output logic                side_r,
    output logic                walk_signal,
    output logic                walk_pending,
    output logic                jam_exists,
    output logic [PHASE_W-1:0]  phase
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [NUM_WALK-1:0] walk_deb;
    logic                walk_set;
    phase_t              state;
    phase_t              next_state;
    lamps_t              lamps;
    logic [CNT_W-1:0]    dwell;
    logic [CNT_W-1:0]    dur;
    logic                leave;
    logic                bad_code;
    logic                jam_tick;
    logic                enter_walk;

    assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_WALK; i++) begin : g_deb
        walk_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
            .clk (clk),
            .rst (rst),
            .raw (walk_req[i]),
            .deb (walk_deb[i])
        );
    end

    assign walk_set = |walk_deb;

    always_comb begin
        dur = CNT_W'(T_WALK);
        case (state)
            MAIN_G:         dur = jam_exists ? CNT_W'(T_JAM_G) : CNT_W'(T_MAIN_G);
            SIDE_G:         dur = jam_exists ? CNT_W'(T_JAM_G) : CNT_W'(T_SIDE_G);
            MAIN_Y, SIDE_Y: dur = CNT_W'(T_YEL);
            default:        dur = CNT_W'(T_WALK);
        endcase
    end

    // ">=" rather than "==" so a jam found after the extended length already passed exits on the next tick.
    assign leave      = tick && (dwell >= dur - 1'b1);
    assign bad_code   = (state > WALK_B);
    assign jam_tick   = tick && ((state == MAIN_G) || (state == SIDE_G))
                        && (dwell == CNT_W'(JAM_SAMPLE - 1));
    assign enter_walk = leave && walk_pending && ((state == MAIN_Y) || (state == SIDE_Y));

    always_comb begin
        next_state = state;
        if (bad_code) begin
            next_state = MAIN_G;
        end else if (leave) begin
            case (state)
                MAIN_G:  next_state = MAIN_Y;
                MAIN_Y:  next_state = walk_pending ? WALK_A : SIDE_G;
                WALK_A:  next_state = SIDE_G;
                SIDE_G:  next_state = SIDE_Y;
                SIDE_Y:  next_state = walk_pending ? WALK_B : MAIN_G;
                default: next_state = MAIN_G;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MAIN_G;
            lamps <= lamp_decode(MAIN_G);
            dwell <= '0;
        end else begin
            state <= next_state;
            lamps <= lamp_decode(next_state);
            if (leave || bad_code) begin
                dwell <= '0;
            end else if (tick) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jam_exists   <= 1'b0;
            walk_pending <= 1'b0;
        end else begin
            if (leave || bad_code) begin
                jam_exists <= 1'b0;
            end else if (jam_tick) begin
                jam_exists <= sensor;
            end
            walk_pending <= walk_set | (walk_pending & ~enter_walk);
        end
    end

    assign main_g      = lamps.main_g;
    assign main_y      = lamps.main_y;
    assign main_r      = lamps.main_r;
    assign side_g      = lamps.side_g;
    assign side_y      = lamps.side_y;
    assign side_r      = lamps.side_r;
    assign walk_signal = lamps.walk;
    assign phase       = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a clk-domain behavioural model and literal duration checks.
module tb_traffic_phase_ctrl;

    localparam int TD = 4, NW = 4, DL = 3;
    localparam int TMG = 12, TSG = 6, TY = 2, TW = 3, TJ = 9, JS = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sensor = 1'b0;
    logic [NW-1:0] walk_req = '0;
    logic          main_g, main_y, main_r, side_g, side_y, side_r;
    logic          walk_signal, walk_pending, jam_exists;
    logic [2:0]    phase;

    traffic_phase_ctrl #(
        .TICK_DIV(TD), .NUM_WALK(NW), .DEB_LEN(DL), .CNT_W(8),
        .T_MAIN_G(TMG), .T_SIDE_G(TSG), .T_YEL(TY), .T_WALK(TW),
        .T_JAM_G(TJ), .JAM_SAMPLE(JS)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .walk_req(walk_req),
        .main_g(main_g), .main_y(main_y), .main_r(main_r),
        .side_g(side_g), .side_y(side_y), .side_r(side_r),
        .walk_signal(walk_signal), .walk_pending(walk_pending),
        .jam_exists(jam_exists), .phase(phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit walk_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: every phase begins aligned to the tick divider, so lengths are plain clk counts.
    int m_state = 0, m_el = 0, m_len = TMG * TD;
    int m_cnt[NW] = '{default: 0};
    bit m_jam = 1'b0, m_pend = 1'b0;

    function automatic int base_len(input int s);
        case (s)
            0:       return TMG * TD;
            3:       return TSG * TD;
            1, 4:    return TY * TD;
            default: return TW * TD;
        endcase
    endfunction

    function automatic logic [6:0] exp_lamps(input int s);
        case (s)
            0:       return 7'b1000010;
            1:       return 7'b0100010;
            3:       return 7'b0011000;
            4:       return 7'b0010100;
            default: return 7'b0010011;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_el = 0; m_len = TMG * TD; m_jam = 0; m_pend = 0;
            for (int i = 0; i < NW; i++) m_cnt[i] = 0;
        end else begin : mdl
            bit set;
            int e;
            set = 1'b0;
            for (int i = 0; i < NW; i++) begin
                if (m_cnt[i] >= DL) set = 1'b1;
                m_cnt[i] = walk_req[i] ? m_cnt[i] + 1 : 0;
            end
            e = m_el + 1;
            if (e >= m_len) begin
                case (m_state)
                    0:       m_state = 1;
                    1:       m_state = m_pend ? 2 : 3;
                    2:       m_state = 3;
                    3:       m_state = 4;
                    4:       m_state = m_pend ? 5 : 0;
                    default: m_state = 0;
                endcase
                if (m_state == 2 || m_state == 5) m_pend = set;
                else m_pend = m_pend | set;
                m_el = 0; m_jam = 0; m_len = base_len(m_state);
            end else begin
                m_el = e;
                m_pend = m_pend | set;
                if ((m_state == 0 || m_state == 3) && e == JS * TD) begin
                    m_jam = sensor;
                    if (m_jam) m_len = (TJ * TD > e) ? TJ * TD : e + TD;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] got, exp;
        #1;
        got = {main_g, main_y, main_r, side_g, side_y, side_r, walk_signal,
               walk_pending, jam_exists, phase};
        exp = {exp_lamps(m_state), m_pend, m_jam, 3'(m_state)};
        if (walk_signal) walk_seen = 1'b1;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL outputs t=%0t got=%b expected=%b", $time, got, exp);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_next(output int t, output int p);
        int cur;
        cur = phase; t = -1; p = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (phase != cur) begin t = cyc; p = phase; break; end
        end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL timeout leaving phase %0d", cur);
        end
    endtask

    task automatic press(input int ch, input int n, output int t0);
        @(negedge clk);
        walk_req[ch] = 1'b1;
        t0 = cyc;
        repeat (n) @(negedge clk);
        walk_req[ch] = 1'b0;
    endtask

    task automatic wait_pending(output int t);
        t = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (walk_pending) begin t = cyc; break; end
        end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL timeout waiting walk_pending");
        end
    endtask

    function automatic int out_vec();
        return int'({main_g, main_y, main_r, side_g, side_y, side_r, walk_signal,
                     walk_pending, jam_exists, phase});
    endfunction

    initial begin
        int t0, t1, tp, p;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", out_vec(), 12'b1000010_0_0_000);
        rst = 1'b0;
        t0 = cyc;

        // Free-running cycle, no requests.
        wait_next(t1, p); check("p_after_main_g", p, 1); check("main_g_len", t1 - t0, 48); t0 = t1;
        wait_next(t1, p); check("p_after_main_y", p, 3); check("main_y_len", t1 - t0, 8);  t0 = t1;
        wait_next(t1, p); check("p_after_side_g", p, 4); check("side_g_len", t1 - t0, 24); t0 = t1;
        wait_next(t1, p); check("p_after_side_y", p, 0); check("side_y_len", t1 - t0, 8);  t0 = t1;
        check("no_walk_lamp", int'(walk_seen), 0);

        // Valid 3-clk press during MAIN_G.
        repeat (5) @(negedge clk);
        press(2, 3, tp);
        wait_pending(t1); check("pending_latency", t1 - tp, 4);
        wait_next(t1, p); check("main_g_len2", t1 - t0, 48);
        wait_next(t1, p); check("walk_a_entered", p, 2); t0 = t1;
        check("pending_cleared_a", int'(walk_pending), 0);
        check("walk_lamp_on", int'(walk_signal), 1);
        wait_next(t1, p); check("after_walk_a", p, 3); check("walk_a_len", t1 - t0, 12); t0 = t1;

        // 2-clk glitch in SIDE_G must not register.
        repeat (3) @(negedge clk);
        press(0, 2, tp);
        repeat (10) @(negedge clk);
        #1;
        check("short_press_ignored", int'(walk_pending), 0);
        wait_next(t1, p); check("side_g_len2", t1 - t0, 24);
        wait_next(t1, p); check("no_walk_b", p, 0); t0 = t1;

        // Jam in MAIN_G extends it to 9 ticks; sensor ignored in MAIN_Y.
        sensor = 1'b1;
        repeat (26) @(negedge clk);
        #1;
        check("jam_set", int'(jam_exists), 1);
        wait_next(t1, p); check("jam_main_g_len", t1 - t0, 36); t0 = t1;
        check("jam_clear_in_y", int'(jam_exists), 0);
        wait_next(t1, p); check("main_y_len_jam", t1 - t0, 8); check("jam_y_stays_0", p, 3);
        sensor = 1'b0;
        wait_next(t1, p);
        wait_next(t1, p); t0 = t1;

        // Request during WALK_A is served at WALK_B.
        repeat (2) @(negedge clk);
        press(1, 3, tp);
        wait_next(t1, p);
        wait_next(t1, p); check("walk_a_entered2", p, 2);
        repeat (2) @(negedge clk);
        press(3, 3, tp);
        wait_pending(t1); check("pending_in_walk_a", t1 - tp, 4);
        wait_next(t1, p);
        wait_next(t1, p);
        wait_next(t1, p); check("walk_b_entered", p, 5); t0 = t1;
        check("pending_cleared_b", int'(walk_pending), 0);
        wait_next(t1, p); check("after_walk_b", p, 0); check("walk_b_len", t1 - t0, 12);

        // Reset with jam set mid-green.
        sensor = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check("jam_before_rst", int'(jam_exists), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", out_vec(), 12'b1000010_0_0_000);
        @(negedge clk);
        rst = 1'b0; sensor = 1'b0; t0 = cyc;
        wait_next(t1, p); check("post_rst_main_g_len", t1 - t0, 48);

        // Reset mid-SIDE_G.
        wait_next(t1, p);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("side_rst_outputs", out_vec(), 12'b1000010_0_0_000);
        @(negedge clk);
        rst = 1'b0; t0 = cyc;
        wait_next(t1, p); check("post_rst2_main_g_len", t1 - t0, 48);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
